// File: rtl/bram_fifo_ctrl_s18.sv
// FWFT FIFO controller around a 1Kx18 dual-port BRAM with a 2-entry output buffer.
// Optional macro BRAM_FIFO_PARITY_CHK_EN: byte parity generation on write, checking on read.
module bram_fifo_ctrl_s18 #(
    parameter int AFULL_LEVEL = 1020
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLR,
    input  logic [17:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [17:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [10:0] LEVEL,
    output logic        AFULL,
    output logic        PAR_ERR,
    output logic [9:0]  RAM_ADDRA,
    output logic [15:0] RAM_DIA,
    output logic [1:0]  RAM_DIPA,
    output logic        RAM_ENA,
    output logic        RAM_WEA,
    output logic [9:0]  RAM_ADDRB,
    output logic        RAM_ENB,
    output logic        RAM_WEB,
    output logic        RAM_SSRA,
    output logic        RAM_SSRB,
    input  logic [15:0] RAM_DOB,
    input  logic [1:0]  RAM_DOPB
);

    localparam logic [10:0] AFULL_LVL = 11'(AFULL_LEVEL);

    logic [9:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [10:0] ram_cnt_q, ram_cnt_d, level_q, level_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  occ_q, occ_d;
    logic [17:0] head_q, head_d, skid_q, skid_d;
    logic        afull_q, afull_d, par_err_q, par_err_d;

    logic        push, pop, issue, par_bad;
    logic [2:0]  buf_need;
    logic [17:0] rd_word;

`ifdef BRAM_FIFO_PARITY_CHK_EN
    logic unused_in_par;
    assign unused_in_par = ^IN_DATA[17:16];
    assign RAM_DIPA = {^IN_DATA[15:8], ^IN_DATA[7:0]};
    assign rd_word  = {2'b00, RAM_DOB};
    assign par_bad  = rd_pend_q & ({^RAM_DOB[15:8], ^RAM_DOB[7:0]} != RAM_DOPB);
`else
    assign RAM_DIPA = IN_DATA[17:16];
    assign rd_word  = {RAM_DOPB, RAM_DOB};
    assign par_bad  = 1'b0;
`endif

    assign IN_READY  = (ram_cnt_q != 11'd1024) & ~CLR & RST_N;
    assign push      = IN_VALID & IN_READY;
    assign OUT_VALID = (occ_q != 2'd0);
    assign OUT_DATA  = head_q;
    assign pop       = OUT_VALID & OUT_READY;

    // Only issue a read if the buffer still has room once the in-flight word lands.
    assign buf_need  = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue     = (ram_cnt_q != 11'd0) & (buf_need < 3'd2) & ~CLR;

    assign RAM_ENA   = push;
    assign RAM_WEA   = push;
    assign RAM_ADDRA = wr_ptr_q;
    assign RAM_DIA   = IN_DATA[15:0];
    assign RAM_ENB   = issue;
    assign RAM_ADDRB = rd_ptr_q;
    assign RAM_WEB   = 1'b0;
    assign RAM_SSRA  = 1'b0;
    assign RAM_SSRB  = 1'b0;

    assign LEVEL   = level_q;
    assign AFULL   = afull_q;
    assign PAR_ERR = par_err_q;

    always_comb begin
        wr_ptr_d  = push  ? wr_ptr_q + 10'd1 : wr_ptr_q;
        rd_ptr_d  = issue ? rd_ptr_q + 10'd1 : rd_ptr_q;
        ram_cnt_d = ram_cnt_q + {10'd0, push} - {10'd0, issue};
        rd_pend_d = issue;
        occ_d     = occ_q - {1'b0, pop} + {1'b0, rd_pend_q};
        head_d    = head_q;
        skid_d    = skid_q;
        par_err_d = par_err_q | par_bad;

        if (pop && occ_q == 2'd2)
            head_d = skid_q;
        // Returning word goes to the head whenever the head slot is free after this pop.
        if (rd_pend_q) begin
            if (occ_q == 2'd0 || (pop && occ_q == 2'd1))
                head_d = rd_word;
            else
                skid_d = rd_word;
        end

        if (CLR) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            rd_pend_d = 1'b0;
            occ_d     = '0;
            par_err_d = 1'b0;
        end

        level_d = ram_cnt_d + {10'd0, rd_pend_d} + {9'd0, occ_d};
        afull_d = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            occ_q     <= '0;
            head_q    <= '0;
            skid_q    <= '0;
            level_q   <= '0;
            afull_q   <= (AFULL_LVL == 11'd0);
            par_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            occ_q     <= occ_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            level_q   <= level_d;
            afull_q   <= afull_d;
            par_err_q <= par_err_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl_s18.sv
// Bench for bram_fifo_ctrl_s18: BRAM model, queue-based reference, vector table and corner sequences.
module tb_bram_fifo_ctrl_s18;

    localparam int AFL = 1020;

    logic        CLK = 1'b0;
    logic        RST_N, CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY, AFULL, PAR_ERR;
    logic [17:0] IN_DATA, OUT_DATA;
    logic [10:0] LEVEL;
    logic [9:0]  RAM_ADDRA, RAM_ADDRB;
    logic [15:0] RAM_DIA, RAM_DOB;
    logic [1:0]  RAM_DIPA, RAM_DOPB;
    logic        RAM_ENA, RAM_WEA, RAM_ENB, RAM_WEB, RAM_SSRA, RAM_SSRB;

    bram_fifo_ctrl_s18 #(.AFULL_LEVEL(AFL)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .LEVEL(LEVEL), .AFULL(AFULL), .PAR_ERR(PAR_ERR),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_DIPA(RAM_DIPA),
        .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_ADDRB(RAM_ADDRB),
        .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_SSRA(RAM_SSRA), .RAM_SSRB(RAM_SSRB),
        .RAM_DOB(RAM_DOB), .RAM_DOPB(RAM_DOPB)
    );

    always #5 CLK = ~CLK;

    // 1Kx18 BRAM model; one selected read can have its parity bit 0 inverted.
    logic [17:0] mem [0:1023];
    logic [17:0] dout = '0;
    int          rd_count = 0;
    int          inject_idx = -1;
    assign RAM_DOB  = dout[15:0];
    assign RAM_DOPB = dout[17:16];
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= {RAM_DIPA, RAM_DIA};
        if (RAM_ENB) begin
            dout     <= mem[RAM_ADDRB] ^ ((rd_count == inject_idx) ? 18'h10000 : 18'h0);
            rd_count <= rd_count + 1;
        end
    end

    int          total = 0, bad = 0;
    logic [17:0] q[$];
    logic        last_push, last_enb, corrupt_next, par_chk;

    function automatic void chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, exp);
        end
    endfunction

    function automatic logic [17:0] exp_out(logic [17:0] d);
`ifdef BRAM_FIFO_PARITY_CHK_EN
        return {2'b00, d[15:0]};
`else
        return d;
`endif
    endfunction

    // One clock: called at a negedge with inputs already applied.
    task automatic cyc();
        logic p, o;
        logic [17:0] w;
        #1;
        p = IN_VALID & IN_READY;
        o = OUT_VALID & OUT_READY;
        chk("collision", int'(RAM_ENA & RAM_ENB & (RAM_ADDRA == RAM_ADDRB)), 0);
        if (!CLR && q.size() < 1024) chk("in_ready_room", int'(IN_READY), 1);
        if (q.size() >= 1026) chk("in_ready_full", int'(IN_READY), 0);
        if (CLR) chk("in_ready_clr", int'(IN_READY), 0);
        if (o) begin
            chk("pop_nonempty", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                chk("pop_data", int'(OUT_DATA), int'(q[0]));
                void'(q.pop_front());
            end
        end
        if (p) begin
            w = exp_out(IN_DATA);
`ifndef BRAM_FIFO_PARITY_CHK_EN
            if (corrupt_next) w = w ^ 18'h10000;
`endif
            corrupt_next = 1'b0;
            q.push_back(w);
        end
        if (CLR) q.delete();
        last_push = p;
        last_enb  = RAM_ENB;
        @(posedge CLK);
        @(negedge CLK);
        chk("level", int'(LEVEL), q.size());
        chk("afull", int'(AFULL), int'(q.size() >= AFL));
        if (OUT_VALID) begin
            chk("ovalid_nonempty", int'(q.size() != 0), 1);
            if (q.size() != 0) chk("head", int'(OUT_DATA), int'(q[0]));
        end
        if (par_chk) chk("par_err_quiet", int'(PAR_ERR), 0);
    endtask

    typedef struct {
        logic iv; logic [17:0] din; logic ordy; logic clr;
        logic exp_irdy; logic exp_ov; logic [17:0] exp_od; int exp_lvl;
    } vec_t;

    vec_t tbl [10];
    int   pushed, guard;
    logic seen_v;

    initial begin
        tbl[0] = '{1'b1, 18'h1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 1};
        tbl[1] = '{1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 1};
        tbl[2] = '{1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h1, 1};
        tbl[3] = '{1'b1, 18'h2, 1'b1, 1'b0, 1'b1, 1'b0, 18'h0, 1};
        tbl[4] = '{1'b1, 18'h3, 1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 2};
        tbl[5] = '{1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h2, 2};
        tbl[6] = '{1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h2, 2};
        tbl[7] = '{1'b0, 18'h0, 1'b1, 1'b0, 1'b1, 1'b1, 18'h3, 1};
        tbl[8] = '{1'b0, 18'h0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h0, 0};
        tbl[9] = '{1'b1, 18'h5, 1'b0, 1'b1, 1'b0, 1'b0, 18'h0, 0};

        corrupt_next = 1'b0; par_chk = 1'b1; last_push = 1'b0; last_enb = 1'b0;
        RST_N = 1'b0; CLR = 1'b0; IN_VALID = 1'b1; IN_DATA = 18'h3; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_in_ready", int'(IN_READY), 0);
        chk("rst_ena", int'(RAM_ENA | RAM_WEA | RAM_ENB | RAM_WEB), 0);
        chk("rst_ovalid", int'(OUT_VALID), 0);
        chk("rst_odata", int'(OUT_DATA), 0);
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_afull", int'(AFULL), 0);
        chk("rst_par", int'(PAR_ERR), 0);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1 chk("post_rst_in_ready", int'(IN_READY), 1);

        // vector table: first-word latency, skid use, push+pop, CLR refusing a push
        for (int i = 0; i < 10; i++) begin
            IN_VALID = tbl[i].iv; IN_DATA = tbl[i].din;
            OUT_READY = tbl[i].ordy; CLR = tbl[i].clr;
            #1 chk($sformatf("vec%0d_irdy", i), int'(IN_READY), int'(tbl[i].exp_irdy));
            cyc();
            chk($sformatf("vec%0d_ov", i), int'(OUT_VALID), int'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) chk($sformatf("vec%0d_od", i), int'(OUT_DATA), int'(tbl[i].exp_od));
            chk($sformatf("vec%0d_lvl", i), int'(LEVEL), tbl[i].exp_lvl);
        end
        CLR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;

        // fill to capacity, then drain across the pointer wrap
        pushed = 0;
        for (guard = 0; guard < 3000 && pushed < 1026; guard++) begin
            IN_VALID = 1'b1; IN_DATA = 18'(pushed);
            cyc();
            if (last_push) pushed++;
        end
        chk("fill_count", pushed, 1026);
        IN_VALID = 1'b1;
        #1;
        chk("fill_in_ready", int'(IN_READY), 0);
        chk("fill_level", int'(LEVEL), 1026);
        chk("fill_afull", int'(AFULL), 1);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (guard = 0; guard < 3000 && q.size() != 0; guard++) cyc();
        chk("drain_level", int'(LEVEL), 0);
        chk("drain_afull", int'(AFULL), 0);

        // streaming: 5000 words, every cycle push and pop, no bubbles once primed
        pushed = 0; seen_v = 1'b0;
        for (guard = 0; guard < 6000 && (pushed < 5000 || q.size() != 0); guard++) begin
            IN_VALID = (pushed < 5000); IN_DATA = 18'(pushed * 7 + 3); OUT_READY = 1'b1;
            cyc();
            if (last_push) pushed++;
            if (seen_v && pushed < 5000) chk("stream_bubble", int'(OUT_VALID), 1);
            if (OUT_VALID) seen_v = 1'b1;
        end
        chk("stream_done", int'(q.size()), 0);

        // random traffic with back-pressure
        for (int k = 0; k < 3000; k++) begin
            IN_VALID = 1'($urandom_range(0, 1)); IN_DATA = 18'($urandom);
            OUT_READY = 1'($urandom_range(0, 1));
            cyc();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (guard = 0; guard < 3000 && q.size() != 0; guard++) cyc();
        chk("rand_drain", int'(LEVEL), 0);

        // CLR at level 37 with a read in flight and a concurrent push
        OUT_READY = 1'b0;
        for (guard = 0; guard < 200 && q.size() < 37; guard++) begin
            IN_VALID = 1'b1; IN_DATA = 18'($urandom);
            cyc();
        end
        OUT_READY = 1'b1;
        repeat (3) cyc();
        chk("clr_level37", int'(LEVEL), 37);
        chk("clr_rd_inflight", int'(last_enb), 1);
        CLR = 1'b1; OUT_READY = 1'b0; IN_DATA = 18'h15555;
        cyc();
        CLR = 1'b0; IN_VALID = 1'b0;
        chk("clr_level", int'(LEVEL), 0);
        chk("clr_ovalid", int'(OUT_VALID), 0);
        chk("clr_push_refused", int'(last_push), 0);
        cyc();
        chk("clr_no_stale", int'(OUT_VALID), 0);
        IN_VALID = 1'b1; IN_DATA = 18'h2AAAA;
        cyc();
        IN_VALID = 1'b0;
        for (guard = 0; guard < 10 && !OUT_VALID; guard++) cyc();
        chk("clr_word_valid", int'(OUT_VALID), 1);
`ifdef BRAM_FIFO_PARITY_CHK_EN
        chk("clr_word", int'(OUT_DATA), 'h0AAAA);
`else
        chk("clr_word", int'(OUT_DATA), 'h2AAAA);
`endif
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;

        // corrupt the parity lane of one read
        par_chk = 1'b0;
        inject_idx = rd_count;
        corrupt_next = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 18'h01234;
        cyc();
        IN_VALID = 1'b0;
        for (guard = 0; guard < 10 && !OUT_VALID; guard++) cyc();
        chk("par_valid", int'(OUT_VALID), 1);
`ifdef BRAM_FIFO_PARITY_CHK_EN
        chk("par_err_set", int'(PAR_ERR), 1);
        chk("par_data", int'(OUT_DATA), 'h01234);
`else
        chk("par_err_off", int'(PAR_ERR), 0);
        chk("par_data_bit16", int'(OUT_DATA), 'h11234);
`endif
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;
        repeat (3) cyc();
`ifdef BRAM_FIFO_PARITY_CHK_EN
        chk("par_err_sticky", int'(PAR_ERR), 1);
`else
        chk("par_err_sticky", int'(PAR_ERR), 0);
`endif
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        chk("par_err_clr", int'(PAR_ERR), 0);
        par_chk = 1'b1;

        // asynchronous reset mid-operation
        for (int k = 0; k < 5; k++) begin
            IN_VALID = 1'b1; IN_DATA = 18'(k + 'h100);
            cyc();
        end
        RST_N = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_level", int'(LEVEL), 0);
        chk("mid_rst_ovalid", int'(OUT_VALID), 0);
        chk("mid_rst_ena", int'(RAM_ENA), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        repeat (2) cyc();
        chk("mid_rst_idle", int'(OUT_VALID), 0);
        IN_VALID = 1'b1; IN_DATA = 18'h0BEEF;
        cyc();
        IN_VALID = 1'b0;
        for (guard = 0; guard < 10 && !OUT_VALID; guard++) cyc();
        chk("mid_rst_word", int'(OUT_DATA), int'(exp_out(18'h0BEEF)));
        OUT_READY = 1'b1;
        cyc();
        chk("final_level", int'(LEVEL), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
